saturation_unit: RTL and testbench

Registered symmetric clamp for signed two's-complement samples. Each clock it limits `din` to the range [-MAX_VAL, +MAX_VAL] and presents the result one cycle later, with flags that mark clipped samples. It sits in DSP datapaths, for example after gain stages or adders, and keeps downstream logic inside a known amplitude range without widening the bus.

---
 rtl/saturation_unit_if.sv | 12 +
 rtl/saturation_unit.sv | 55 +++++
 tb/tb_saturation_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/saturation_unit_if.sv
// Sample bus for the symmetric clamp: raw sample in, clamped sample and clip flags out.
interface saturation_unit_if #(
  parameter int DATA_WIDTH = 8
);
  logic signed [DATA_WIDTH-1:0] din;
  logic signed [DATA_WIDTH-1:0] dout;
  logic                         sat_hi;
  logic                         sat_lo;

  modport master (output din, input dout, input sat_hi, input sat_lo);
  modport slave  (input din, output dout, output sat_hi, output sat_lo);
endinterface

// File: rtl/saturation_unit.sv
// Registered symmetric clamp: limits each signed sample to [-MAX_VAL, +MAX_VAL]
// with one cycle of latency and flags marking clipped samples.
module saturation_unit #(
  parameter int     DATA_WIDTH = 8,
  parameter longint MAX_VAL    = 15
) (
  input logic              clk,
  input logic              resetn,
  saturation_unit_if.slave bus
);

  localparam longint LIMIT_MAX = (DATA_WIDTH >= 64) ? 64'sh7fff_ffff_ffff_ffff
                                 : ((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);

  generate
    if (DATA_WIDTH < 2 || DATA_WIDTH > 64) begin : g_bad_width
      $error("saturation_unit: DATA_WIDTH must be in 2..64");
    end
    if (MAX_VAL <= 0 || MAX_VAL > LIMIT_MAX) begin : g_bad_max
      $error("saturation_unit: MAX_VAL must be in 1..2^(DATA_WIDTH-1)-1");
    end
  endgenerate

  // Negating POS_LIM cannot overflow since it never exceeds the largest positive code.
  localparam logic signed [DATA_WIDTH-1:0] POS_LIM = DATA_WIDTH'(MAX_VAL);
  localparam logic signed [DATA_WIDTH-1:0] NEG_LIM = -POS_LIM;

  logic                         above;
  logic                         below;
  logic signed [DATA_WIDTH-1:0] dout_next;

  always_comb begin
    above     = $signed(bus.din) > POS_LIM;
    below     = $signed(bus.din) < NEG_LIM;
    dout_next = bus.din;
    if (above) begin
      dout_next = POS_LIM;
    end else if (below) begin
      dout_next = NEG_LIM;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.dout   <= '0;
      bus.sat_hi <= 1'b0;
      bus.sat_lo <= 1'b0;
    end else begin
      bus.dout   <= dout_next;
      bus.sat_hi <= above;
      bus.sat_lo <= below;
    end
  end

endmodule

// File: tb/tb_saturation_unit.sv
// Bench for saturation_unit: directed scenarios, full code sweeps and random samples
// on two instances (MAX_VAL 15 and 127) against an integer clamp model.
module tb_saturation_unit;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;

  saturation_unit_if #(.DATA_WIDTH(8)) bus_a ();
  saturation_unit_if #(.DATA_WIDTH(8)) bus_b ();

  saturation_unit #(.DATA_WIDTH(8), .MAX_VAL(15)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_a.slave)
  );

  saturation_unit #(.DATA_WIDTH(8), .MAX_VAL(127)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_b.slave)
  );

  wire [9:0] obs_a = {bus_a.dout, bus_a.sat_hi, bus_a.sat_lo};
  wire [9:0] obs_b = {bus_b.dout, bus_b.sat_hi, bus_b.sat_lo};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {dout, sat_hi, sat_lo} for sample x under limit m, in plain integers.
  function automatic logic [9:0] model(input int x, input int m);
    int   y;
    logic hi;
    logic lo;
    y  = x;
    hi = 1'b0;
    lo = 1'b0;
    if (x > m) begin
      y  = m;
      hi = 1'b1;
    end else if (x < -m) begin
      y  = -m;
      lo = 1'b1;
    end
    return {8'(y), hi, lo};
  endfunction

  task automatic drive(input int v);
    bus_a.din = 8'(v);
    bus_b.din = 8'(v);
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    drive(0);
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if (obs_a !== 10'h000) begin
      n_err++;
      $display("FAIL reset_async_a: got %h want %h", obs_a, 10'h000);
    end
    n_cmp++;
    if (obs_b !== 10'h000) begin
      n_err++;
      $display("FAIL reset_async_b: got %h want %h", obs_b, 10'h000);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs_a !== 10'h000) begin
      n_err++;
      $display("FAIL reset_held_a: got %h want %h", obs_a, 10'h000);
    end
    resetn = 1'b1;
  endtask

  task automatic test_step();
    drive(0);
    @(negedge clk);
    n_cmp++;
    if (obs_a !== model(0, 15)) begin
      n_err++;
      $display("FAIL step_zero: got %h want %h", obs_a, model(0, 15));
    end
    drive(1);
    #1;
    n_cmp++;
    if (obs_a !== model(0, 15)) begin
      n_err++;
      $display("FAIL step_no_early_change: got %h want %h", obs_a, model(0, 15));
    end
    @(negedge clk);
    n_cmp++;
    if (obs_a !== model(1, 15)) begin
      n_err++;
      $display("FAIL step_one: got %h want %h", obs_a, model(1, 15));
    end
  endtask

  task automatic test_clip_pulse();
    int seq[$];
    for (int i = 0; i < 10; i++) seq.push_back(1);
    seq.push_back(18);
    seq.push_back(1);
    seq.push_back(1);
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      n_cmp++;
      if (obs_a !== model(seq[i], 15)) begin
        n_err++;
        $display("FAIL clip_pulse[%0d] din=%0d: got %h want %h", i, seq[i], obs_a, model(seq[i], 15));
      end
    end
  endtask

  task automatic test_small_neg();
    int seq[4] = '{1, 0, -1, -2};
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      n_cmp++;
      if (obs_a !== model(seq[i], 15)) begin
        n_err++;
        $display("FAIL small_neg[%0d] din=%0d: got %h want %h", i, seq[i], obs_a, model(seq[i], 15));
      end
    end
  endtask

  task automatic test_boundaries();
    int seq[6] = '{15, -15, -16, -128, 16, 127};
    foreach (seq[i]) begin
      drive(seq[i]);
      @(negedge clk);
      n_cmp++;
      if (obs_a !== model(seq[i], 15)) begin
        n_err++;
        $display("FAIL boundary_a din=%0d: got %h want %h", seq[i], obs_a, model(seq[i], 15));
      end
      n_cmp++;
      if (obs_b !== model(seq[i], 127)) begin
        n_err++;
        $display("FAIL boundary_b din=%0d: got %h want %h", seq[i], obs_b, model(seq[i], 127));
      end
    end
  endtask

  task automatic test_midcycle_reset();
    drive(100);
    @(negedge clk);
    n_cmp++;
    if (obs_a !== model(100, 15)) begin
      n_err++;
      $display("FAIL pre_reset_100: got %h want %h", obs_a, model(100, 15));
    end
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if (obs_a !== 10'h000) begin
      n_err++;
      $display("FAIL midcycle_reset_clear: got %h want %h", obs_a, 10'h000);
    end
    @(negedge clk);
    n_cmp++;
    if (obs_a !== 10'h000) begin
      n_err++;
      $display("FAIL midcycle_reset_hold: got %h want %h", obs_a, 10'h000);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs_a !== model(100, 15)) begin
      n_err++;
      $display("FAIL post_release_100: got %h want %h", obs_a, model(100, 15));
    end
  endtask

  task automatic test_sweep();
    for (int v = -128; v <= 127; v++) begin
      drive(v);
      @(negedge clk);
      n_cmp++;
      if (obs_a !== model(v, 15)) begin
        n_err++;
        $display("FAIL sweep_a din=%0d: got %h want %h", v, obs_a, model(v, 15));
      end
      n_cmp++;
      if (obs_b !== model(v, 127)) begin
        n_err++;
        $display("FAIL sweep_b din=%0d: got %h want %h", v, obs_b, model(v, 127));
      end
      n_cmp++;
      if ((bus_a.sat_hi & bus_a.sat_lo) !== 1'b0 || (bus_b.sat_hi & bus_b.sat_lo) !== 1'b0) begin
        n_err++;
        $display("FAIL flags_exclusive din=%0d: got a=%b%b b=%b%b want no pair of 11", v,
                 bus_a.sat_hi, bus_a.sat_lo, bus_b.sat_hi, bus_b.sat_lo);
      end
    end
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 300; i++) begin
      v = int'($urandom_range(255)) - 128;
      drive(v);
      @(negedge clk);
      n_cmp++;
      if (obs_a !== model(v, 15) || obs_b !== model(v, 127)) begin
        n_err++;
        $display("FAIL random[%0d] din=%0d: got a=%h b=%h want a=%h b=%h", i, v,
                 obs_a, obs_b, model(v, 15), model(v, 127));
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_step();
    test_clip_pulse();
    test_small_neg();
    test_boundaries();
    test_midcycle_reset();
    test_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
